// File: rtl/shift_pkg.sv
// Shared definitions for the shifter result stage: FS encodings, entry layout
// and skid buffer state encoding.
package shift_pkg;

  localparam logic [4:0] FS_SLL = 5'h0C;
  localparam logic [4:0] FS_SRL = 5'h0D;
  localparam logic [4:0] FS_SRA = 5'h0E;

  typedef struct packed {
    logic [4:0]  fs;
    logic [31:0] data;
    logic        c;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/shift_skid_buf.sv
// Generic two-entry valid/ready skid buffer. The main entry drives the outputs
// and the skid entry absorbs one beat while downstream stalls.
module shift_skid_buf
  import shift_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output skid_state_t  state
);

  // Handshake: a beat transfers on a rising edge where valid & ready are both
  // high; valid never waits on ready, and in_ready decodes registered state only.
  skid_state_t  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept;
  logic         release_ev;

  assign in_ready   = (state_q != SKID_FULL);
  assign out_valid  = (state_q != SKID_EMPTY);
  assign out_data   = main_q;
  assign state      = state_q;
  assign accept     = in_valid & in_ready;
  assign release_ev = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (accept && release_ev) begin
          main_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = SKID_FULL;
        end else if (release_ev) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (release_ev) begin
          main_d  = skid_q;
          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SKID_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/shift_result_stage.sv
// Registered result stage behind the barrel shifter with N/Z/C flag ownership.
// Optional performance counters are enabled with SHFT_PERF_CNT_EN.
module shift_result_stage
  import shift_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    FS,
  input  logic [DW-1:0] SHFT_OUT,
  input  logic          C,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] RESULT,
  output logic [4:0]    out_fs,
  output logic          N_FLG,
  output logic          Z_FLG,
  output logic          C_FLG,
`ifdef SHFT_PERF_CNT_EN
  input  logic          cnt_clr,
  output logic [15:0]   ops_cnt,
  output logic [15:0]   stall_cnt,
`endif
  output skid_state_t   dbg_state
);

  entry_t in_entry;
  entry_t main_entry;
  logic   release_ev;

  assign in_entry = '{fs: FS, data: SHFT_OUT, c: C};

  shift_skid_buf #(
    .W (ENTRY_W)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (main_entry),
    .state     (dbg_state)
  );

  assign RESULT     = main_entry.data;
  assign out_fs     = main_entry.fs;
  assign release_ev = out_valid & out_ready;

  // Flags follow the entry leaving the stage; SRA keeps the previous carry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      N_FLG <= 1'b0;
      Z_FLG <= 1'b0;
      C_FLG <= 1'b0;
    end else if (release_ev) begin
      case (main_entry.fs)
        FS_SLL, FS_SRL: begin
          N_FLG <= main_entry.data[31];
          Z_FLG <= (main_entry.data == 32'd0);
          C_FLG <= main_entry.c;
        end
        FS_SRA: begin
          N_FLG <= main_entry.data[31];
          Z_FLG <= (main_entry.data == 32'd0);
        end
        default: ;
      endcase
    end
  end

`ifdef SHFT_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ops_cnt   <= 16'd0;
      stall_cnt <= 16'd0;
    end else if (cnt_clr) begin
      ops_cnt   <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (release_ev && (ops_cnt != 16'hFFFF))
        ops_cnt <= ops_cnt + 16'd1;
      if (out_valid && !out_ready && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
